// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and parity mode codes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Line synchronizer plus 3-sample majority voter for the UART receiver.
// vote is the majority of rxs over this cycle and the two before it.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic sampleclk,
  input  logic reset,
  input  logic uart_rx,
  output logic rxs,
  output logic vote
);

  logic       meta;
  logic [1:0] hist;

  // Flops reset to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge sampleclk) begin
    if (reset) begin
      meta <= 1'b1;
      rxs  <= 1'b1;
      hist <= 2'b11;
    end else begin
      meta <= uart_rx;
      rxs  <= meta;
      hist <= {hist[0], rxs};
    end
  end

  assign vote = maj3({hist, rxs});

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: start/data/parity/stop FSM with a one-deep
// holding register and valid/ready handoff.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 sampleclk,
  input  logic                 reset,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  input  logic                 RX_READY,
  output logic                 PARITY_ERR,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
  output logic                 RX_BUSY
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_core: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 8 || OVERSAMPLE > 64 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_core: OVERSAMPLE must be even and 8..64");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $error("uart_rx_core: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_core: STOP_BITS must be 1 or 2");
  end

  localparam int            CW      = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] VOTE_AT = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] LAST_T  = CW'(OVERSAMPLE - 1);
  localparam logic          PAR_EXP = (PARITY == PAR_ODD);

  uart_state_e          state;
  logic [CW-1:0]        tcnt;
  logic [DATA_BITS-1:0] bit_oh;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 ferr_acc;
  logic                 stop_idx;
  logic                 armed;
  logic                 rxs;
  logic                 vote;
  logic                 mid;
  logic                 eob;
  logic                 last_stop;
  logic                 handshake;
  logic                 frame_perr;
  logic                 frame_ferr;

  uart_rx_sync u_sync (
    .sampleclk (sampleclk),
    .reset     (reset),
    .uart_rx   (UART_RX),
    .rxs       (rxs),
    .vote      (vote)
  );

  assign mid        = (tcnt == VOTE_AT);
  assign eob        = (tcnt == LAST_T);
  assign last_stop  = (STOP_BITS == 1) ? 1'b1 : stop_idx;
  assign handshake  = RX_VALID & RX_READY;
  assign frame_perr = (PARITY != PAR_NONE) && ((^shreg ^ par_bit) != PAR_EXP);
  assign frame_ferr = ferr_acc | ~vote;
  assign RX_BUSY    = (state != ST_IDLE);

  always_ff @(posedge sampleclk) begin
    if (reset) begin
      state      <= ST_IDLE;
      tcnt       <= '0;
      bit_oh     <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      ferr_acc   <= 1'b0;
      stop_idx   <= 1'b0;
      armed      <= 1'b0;
      RX_DATA    <= '0;
      RX_VALID   <= 1'b0;
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      if (state == ST_IDLE) tcnt <= (armed && !rxs) ? CW'(1) : '0;
      else                  tcnt <= eob ? '0 : tcnt + 1'b1;

      // Completion below overrides this when a frame lands in the same cycle.
      if (handshake) begin
        RX_VALID   <= 1'b0;
        PARITY_ERR <= 1'b0;
        FRAME_ERR  <= 1'b0;
        OVERRUN    <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (rxs) armed <= 1'b1;
          else if (armed) begin
            state    <= ST_START;
            bit_oh   <= DATA_BITS'(1);
            ferr_acc <= 1'b0;
            stop_idx <= 1'b0;
          end
        end
        ST_START: begin
          if (mid && vote) state <= ST_IDLE;
          else if (eob)    state <= ST_DATA;
        end
        ST_DATA: begin
          if (mid) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (eob) begin
            bit_oh <= bit_oh << 1;
            if (bit_oh[DATA_BITS-1]) state <= (PARITY == PAR_NONE) ? ST_STOP : ST_PAR;
          end
        end
        ST_PAR: begin
          if (mid) par_bit <= vote;
          if (eob) state <= ST_STOP;
        end
        ST_STOP: begin
          if (mid) begin
            if (last_stop) begin
              // Leave mid-bit so the next start edge can be caught early.
              state <= ST_IDLE;
              armed <= 1'b0;
              if (!RX_VALID || RX_READY) begin
                RX_DATA    <= shreg;
                PARITY_ERR <= frame_perr;
                FRAME_ERR  <= frame_ferr;
                RX_VALID   <= 1'b1;
              end else begin
                OVERRUN <= 1'b1;
              end
            end else begin
              ferr_acc <= ferr_acc | ~vote;
            end
          end else if (eob) begin
            stop_idx <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: an 8N1/x16 instance and an 8E2/x8 instance, driven
// bit-by-bit on the serial line and checked against a frame-level model.
module tb_uart_rx_core;

  logic       sampleclk = 1'b0;
  logic       reset;
  logic       line0, line1, ready0, ready1;
  logic [7:0] data0, data1;
  logic       valid0, pe0, fe0, ov0, busy0;
  logic       valid1, pe1, fe1, ov1, busy1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0_0  = 0;
  int t0_1  = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } rx_t;

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic [1:0] stop;
    logic       perr;
    logic       ferr;
  } vec_t;

  rx_t q0[$];
  rx_t q1[$];

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut0 (
    .sampleclk (sampleclk), .reset (reset), .UART_RX (line0),
    .RX_DATA (data0), .RX_VALID (valid0), .RX_READY (ready0),
    .PARITY_ERR (pe0), .FRAME_ERR (fe0), .OVERRUN (ov0), .RX_BUSY (busy0)
  );

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY(2), .STOP_BITS(2)) dut1 (
    .sampleclk (sampleclk), .reset (reset), .UART_RX (line1),
    .RX_DATA (data1), .RX_VALID (valid1), .RX_READY (ready1),
    .PARITY_ERR (pe1), .FRAME_ERR (fe1), .OVERRUN (ov1), .RX_BUSY (busy1)
  );

  always #5 sampleclk = ~sampleclk;
  always @(posedge sampleclk) cyc <= cyc + 1;

  // Record every transfer, sampled after inputs settle and before the next edge.
  always @(negedge sampleclk) begin
    #2;
    if (!reset && valid0 && ready0) q0.push_back('{data0, pe0, fe0, cyc});
    if (!reset && valid1 && ready1) q1.push_back('{data1, pe1, fe1, cyc});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Reference model: frame-level rules only.
  function automatic logic ref_perr_even(input logic [7:0] d, input logic p);
    return (($countones(d) + int'(p)) % 2) == 1;
  endfunction

  function automatic int ref_lat(input int last_bit_idx, input int os);
    // 2 sync cycles, bit start, mid vote at os/2+1, one cycle to register.
    return 2 + last_bit_idx * os + os / 2 + 1 + 1;
  endfunction

  task automatic hold0(input logic v, input int n);
    line0 = v;
    repeat (n) @(negedge sampleclk);
  endtask

  task automatic hold1(input logic v, input int n);
    line1 = v;
    repeat (n) @(negedge sampleclk);
  endtask

  task automatic send0(input logic [7:0] d);
    t0_0 = cyc;
    hold0(1'b0, 16);
    for (int i = 0; i < 8; i++) hold0(d[i], 16);
    hold0(1'b1, 16);
  endtask

  task automatic send1(input logic [7:0] d, input logic pbit, input logic [1:0] stop);
    t0_1 = cyc;
    hold1(1'b0, 8);
    for (int i = 0; i < 8; i++) hold1(d[i], 8);
    hold1(pbit, 8);
    hold1(stop[0], 8);
    hold1(stop[1], 8);
  endtask

  task automatic expect_rx(input string nm, input int which, input logic [7:0] d,
                           input logic pe, input logic fe, input int lat);
    rx_t r;
    int  n;
    n = (which == 0) ? q0.size() : q1.size();
    chk({nm, " frames"}, n, 1);
    if (n != 0) begin
      r = (which == 0) ? q0.pop_front() : q1.pop_front();
      chk({nm, " data"}, r.data, d);
      chk({nm, " perr"}, r.perr, pe);
      chk({nm, " ferr"}, r.ferr, fe);
      if (lat >= 0) chk({nm, " latency"}, r.cyc - ((which == 0) ? t0_0 : t0_1), lat);
    end
    q0.delete();
    q1.delete();
  endtask

  initial begin
    vec_t       tbl[7];
    logic [7:0] rd;
    logic       rp;
    logic [1:0] rs;
    int         lat0, lat1;

    lat0 = ref_lat(9, 16);
    lat1 = ref_lat(11, 8);
    tbl = '{
      '{8'h07, 1'b0, 2'b11, 1'b1, 1'b0},
      '{8'h07, 1'b1, 2'b11, 1'b0, 1'b0},
      '{8'h00, 1'b0, 2'b11, 1'b0, 1'b0},
      '{8'hFF, 1'b0, 2'b11, 1'b0, 1'b0},
      '{8'h80, 1'b0, 2'b11, 1'b1, 1'b0},
      '{8'h3C, 1'b1, 2'b10, 1'b1, 1'b1},
      '{8'h55, 1'b0, 2'b01, 1'b0, 1'b1}
    };

    reset = 1'b1; line0 = 1'b1; line1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
    repeat (3) @(negedge sampleclk);
    chk("rst data0", data0, 8'h00);
    chk("rst valid0", valid0, 1'b0);
    chk("rst perr0", pe0, 1'b0);
    chk("rst ferr0", fe0, 1'b0);
    chk("rst ovr0", ov0, 1'b0);
    chk("rst busy0", busy0, 1'b0);
    chk("rst valid1", valid1, 1'b0);
    chk("rst busy1", busy1, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge sampleclk);

    // 8N1 0xA5, valid at tick 154 for one cycle
    send0(8'hA5);
    hold0(1'b1, 16);
    expect_rx("8n1 a5", 0, 8'hA5, 1'b0, 1'b0, lat0);
    chk("8n1 valid low after", valid0, 1'b0);

    // Short glitch is a false start
    hold0(1'b0, 3);
    hold0(1'b1, 4);
    chk("glitch busy", busy0, 1'b1);
    hold0(1'b1, 24);
    chk("glitch idle", busy0, 1'b0);
    chk("glitch no frame", q0.size(), 0);

    // Even parity / two stop bits, table-driven
    foreach (tbl[i]) begin
      send1(tbl[i].data, tbl[i].pbit, tbl[i].stop);
      hold1(1'b1, 16);
      expect_rx($sformatf("tbl%0d", i), 1, tbl[i].data, tbl[i].perr, tbl[i].ferr, lat1);
    end

    // Overrun: second frame dropped, held frame intact
    ready0 = 1'b0;
    send0(8'h11);
    send0(8'h22);
    hold0(1'b1, 16);
    chk("ovr valid", valid0, 1'b1);
    chk("ovr data held", data0, 8'h11);
    chk("ovr flag", ov0, 1'b1);
    chk("ovr no transfer", q0.size(), 0);
    ready0 = 1'b1;
    @(negedge sampleclk);
    chk("ovr valid cleared", valid0, 1'b0);
    chk("ovr flag cleared", ov0, 1'b0);
    expect_rx("ovr xfer", 0, 8'h11, 1'b0, 1'b0, -1);

    // Break: one frame with framing error, then a clean frame
    hold0(1'b0, 20 * 16);
    hold0(1'b1, 32);
    expect_rx("break", 0, 8'h00, 1'b0, 1'b1, -1);
    send0(8'h5A);
    hold0(1'b1, 16);
    expect_rx("after break", 0, 8'h5A, 1'b0, 1'b0, lat0);

    // Reset in data bit 4 abandons the frame
    hold0(1'b0, 16);
    for (int i = 0; i < 4; i++) hold0(rd[0], 0);
    rd = 8'h3C;
    for (int i = 0; i < 4; i++) hold0(rd[i], 16);
    hold0(rd[4], 8);
    chk("midrst busy before", busy0, 1'b1);
    reset = 1'b1;
    @(negedge sampleclk);
    chk("midrst data", data0, 8'h00);
    chk("midrst valid", valid0, 1'b0);
    chk("midrst perr", pe0, 1'b0);
    chk("midrst ferr", fe0, 1'b0);
    chk("midrst ovr", ov0, 1'b0);
    chk("midrst busy", busy0, 1'b0);
    line0 = 1'b1;
    reset = 1'b0;
    hold0(1'b1, 48);
    chk("midrst no frame", q0.size(), 0);
    send0(8'h3C);
    hold0(1'b1, 16);
    expect_rx("after rst", 0, 8'h3C, 1'b0, 1'b0, lat0);

    // Randomized frames on the 8N1 instance
    for (int i = 0; i < 25; i++) begin
      rd = 8'($urandom());
      send0(rd);
      expect_rx($sformatf("rnd0_%0d", i), 0, rd, 1'b0, 1'b0, lat0);
      hold0(1'b1, $urandom_range(0, 24));
    end

    // Randomized frames with parity and stop-bit corruption on the 8E2 instance
    for (int i = 0; i < 25; i++) begin
      rd = 8'($urandom());
      rp = 1'($urandom());
      rs = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      send1(rd, rp, rs);
      hold1(1'b1, $urandom_range(2, 12));
      expect_rx($sformatf("rnd1_%0d", i), 1, rd, ref_perr_even(rd, rp), rs != 2'b11, lat1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock port sampleclk, reset port reset.
REQ-002 The block SHALL provide these parameters (name, default, meaning):
- DATA_BITS, 8, payload bits per frame, legal 5..9
- OVERSAMPLE, 16, sampleclk cycles per bit, even, legal 8..64
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even
- STOP_BITS, 1, stop bits per frame, legal 1..2
REQ-003 The block SHALL provide these ports (name, direction, width, meaning):
- sampleclk, in, 1, sample clock
- reset, in, 1, synchronous active-high reset
- UART_RX, in, 1, asynchronous serial line, idle high
- RX_DATA, out, DATA_BITS, received payload, LSB first on the line
- RX_VALID, out, 1, holding register full
- RX_READY, in, 1, consumer accepts; transfer occurs when RX_VALID and RX_READY are both 1
- PARITY_ERR, out, 1, parity mismatch for the held frame
- FRAME_ERR, out, 1, a stop bit was voted 0 in the held frame
- OVERRUN, out, 1, sticky; a frame was dropped
- RX_BUSY, out, 1, state is not IDLE

Function
REQ-004 UART_RX SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rxs).
REQ-005 The FSM states SHALL be IDLE, START, DATA, PAR, STOP; PAR is skipped when PARITY=0.
REQ-006 In IDLE, the block SHALL be armed only after rxs=1 has been seen for at least one cycle since leaving STOP.
REQ-007 Tick 0 SHALL be the first cycle with rxs=0 while armed in IDLE.
REQ-008 Bit k SHALL span ticks k*OVERSAMPLE to k*OVERSAMPLE+OVERSAMPLE-1, with the start bit as k=0.
REQ-009 Each bit value SHALL be the 2-of-3 majority of rxs at offsets OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
REQ-010 A start-bit vote of 1 SHALL be treated as a false start: return to IDLE with no output change.
REQ-011 Data bits SHALL be shifted in LSB first; a DATA_BITS-wide bit counter SHALL select the next state.
REQ-012 The parity check SHALL compute XOR(data, parity bit): expected 1 for odd, 0 for even; any mismatch sets the frame's parity error.
REQ-013 Any stop bit voted 0 SHALL set the frame's framing error.
REQ-014 The FSM SHALL leave STOP for IDLE on the cycle after the final stop-bit vote, not at the end of the bit, to allow resynchronization.
REQ-015 Frame completion SHALL occur in the cycle after the final stop-bit vote.
- 8N1 example: RX_VALID rises at tick 154.
REQ-016 On completion with RX_VALID=0, or with a handshake in the same cycle, RX_DATA, PARITY_ERR and FRAME_ERR SHALL load together and RX_VALID SHALL be 1.
REQ-017 On completion with RX_VALID=1 and no handshake, the new frame SHALL be discarded, the held frame left unchanged, and OVERRUN set to 1.
REQ-018 A handshake without completion SHALL clear RX_VALID, PARITY_ERR, FRAME_ERR and OVERRUN.
REQ-019 RX_DATA and the error flags SHALL remain stable while RX_VALID=1.
REQ-020 A break (line held low) SHALL yield at most one frame, flagged with FRAME_ERR; REQ-006 then blocks new frames until the line returns high.

Reset
REQ-021 While reset=1 at a sampleclk edge, the FSM SHALL go to IDLE (unarmed), all counters to 0, synchronizer flops to 1, and every output to 0.
REQ-022 Reset SHALL take effect mid-frame, abandoning the partial frame with no RX_VALID.

Structure
REQ-023 Package uart_pkg SHALL hold the FSM state enum and the PARITY mode constants (PAR_NONE, PAR_ODD, PAR_EVEN), shared with the future transmitter.
REQ-024 One sub-module, uart_rx_sync, SHALL contain the 2-flop synchronizer and the 3-sample majority voter; the FSM, counters and holding register SHALL stay in uart_rx_core.
REQ-025 The RTL SHALL check parameter legality at elaboration.

Verification
REQ-026 8N1, OVERSAMPLE=16: send 0xA5 with RX_READY=1 -> RX_DATA=0xA5, RX_VALID=1 for exactly one cycle at tick 154, no error flags.
REQ-027 A 3-cycle low glitch on an idle line -> RX_BUSY returns to 0 and RX_VALID is never asserted.
REQ-028 PARITY=2: send 0x07 with parity bit 0 -> RX_DATA=0x07, PARITY_ERR=1; the same frame with parity bit 1 -> PARITY_ERR=0.
REQ-029 Send 0x11 then 0x22 back-to-back with RX_READY=0 -> RX_DATA stays 0x11 and OVERRUN=1; then RX_READY=1 -> one transfer, and RX_VALID=0, OVERRUN=0 next cycle.
REQ-030 Line low for 20 bit times, then high -> exactly one frame with RX_DATA=0x00, FRAME_ERR=1; a following 0x5A is then received cleanly.
REQ-031 Assert reset during data bit 4 -> all outputs 0 the next cycle, no RX_VALID; a subsequent 0x3C is received correctly.
